// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU: fetch in T0-T2, opcode-dependent execute in T3-T7.
// All datapath strobes are a combinational decode of the registered step plus the opcode in IR.
module control_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        stop,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        PCout,
   output logic        PCin,
   output logic        Inc_PC,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        read,
   output logic        write,
   output logic        Yin,
   output logic        Zin,
   output logic        ZLOWout,
   output logic        ZHIout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        inPortout,
   output logic        outPort_in,
   output logic        CONin,
   output logic [4:0]  ALU_select,
   output logic        run
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] ALU_ADD = 5'b00011;
   localparam logic [4:0] ALU_AND = 5'b00101;
   localparam logic [4:0] ALU_OR  = 5'b00110;

   state_t     state_q, state_d;
   logic [4:0] op;
   logic       last;
   logic       ir_unused;

   assign op        = IR[31:27];
   assign ir_unused = ^IR[26:0];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_RESET;
      else     state_q <= state_d;
   end

   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; Inc_PC = 1'b0; IRin = 1'b0; MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; read = 1'b0; write = 1'b0; Yin = 1'b0; Zin = 1'b0;
      ZLOWout = 1'b0; ZHIout = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0;
      LOout = 1'b0; Cout = 1'b0; inPortout = 1'b0; outPort_in = 1'b0; CONin = 1'b0;
      ALU_select = 5'b00000;
      run = 1'b1;
      last = 1'b0;
      case (state_q)
         S_RESET, S_HALT: run = 1'b0;
         S_T0: begin PCout = 1'b1; MARin = 1'b1; Inc_PC = 1'b1; end
         S_T1: begin read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         default: begin
            // Execute steps: the opcode selects both the strobes and the final step.
            if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
               case (state_q)
                  S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                  S_T4: begin Cout = 1'b1; ALU_select = ALU_ADD; Zin = 1'b1; end
                  S_T5: begin
                     ZLOWout = 1'b1;
                     if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                     else MARin = 1'b1;
                  end
                  S_T6: begin
                     MDRin = 1'b1;
                     if (op == OP_LD) read = 1'b1;
                     else begin Gra = 1'b1; Rout = 1'b1; end
                  end
                  default: begin
                     last = 1'b1;
                     if (op == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     else write = 1'b1;
                  end
               endcase
            end else if ((op >= 5'b00011 && op <= 5'b01011) || op == OP_ADDI ||
                         op == OP_ANDI || op == OP_ORI) begin
               case (state_q)
                  S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  S_T4: begin
                     Zin = 1'b1;
                     case (op)
                        OP_ADDI: begin Cout = 1'b1; ALU_select = ALU_ADD; end
                        OP_ANDI: begin Cout = 1'b1; ALU_select = ALU_AND; end
                        OP_ORI:  begin Cout = 1'b1; ALU_select = ALU_OR;  end
                        default: begin Grc = 1'b1; Rout = 1'b1; ALU_select = op; end
                     endcase
                  end
                  default: begin ZLOWout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
               endcase
            end else if (op == OP_MUL || op == OP_DIV) begin
               case (state_q)
                  S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  S_T4: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_select = op; end
                  S_T5: begin ZLOWout = 1'b1; LOin = 1'b1; end
                  default: begin ZHIout = 1'b1; HIin = 1'b1; last = 1'b1; end
               endcase
            end else if (op == OP_NEG || op == OP_NOT) begin
               if (state_q == S_T3) begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_select = op;
               end else begin
                  ZLOWout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1;
               end
            end else if (op == OP_BR) begin
               case (state_q)
                  S_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                  S_T4: begin PCout = 1'b1; Yin = 1'b1; end
                  S_T5: begin Cout = 1'b1; ALU_select = ALU_ADD; Zin = 1'b1; end
                  default: begin
                     // CON_FF was loaded from CONin in T3; it gates the taken-branch write here.
                     last = 1'b1;
                     if (CON_FF) begin ZLOWout = 1'b1; PCin = 1'b1; end
                  end
               endcase
            end else begin
               last = 1'b1;
               case (op)
                  OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  OP_IN:   begin inPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPort_in = 1'b1; end
                  OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_HALT:  state_d = S_HALT;
         default: begin
            if (last) begin
               state_d = (stop || op == OP_HALT) ? S_HALT : S_T0;
            end else begin
               case (state_q)
                  S_T3:    state_d = S_T4;
                  S_T4:    state_d = S_T5;
                  S_T5:    state_d = S_T6;
                  S_T6:    state_d = S_T7;
                  default: state_d = S_T0;
               endcase
            end
         end
      endcase
   end

endmodule
